// File: rtl/ctrl_flag_pipe_pkg.sv
// Shared definitions for the control-flag pipeline: flag bit map, slice widths,
// stage register layouts and helpers that split a control word per stage.
package ctrl_flag_pipe_pkg;

   localparam int FLAG_W = 10;
   localparam int REG_W  = 5;
   localparam int CNT_W  = 16;

   localparam int F_REGDST   = 9;
   localparam int F_ALUSRC   = 8;
   localparam int F_MEMTOREG = 7;
   localparam int F_REGWRITE = 6;
   localparam int F_MEMREAD  = 5;
   localparam int F_MEMWRITE = 4;
   localparam int F_BRANCH   = 3;
   localparam int F_JUMP     = 2;
   localparam int F_ALUOP    = 0;

   localparam int ALUOP_W    = 2;
   localparam int EX_CTRL_W  = 4;
   localparam int MEM_CTRL_W = 4;
   localparam int WB_CTRL_W  = 2;

   localparam logic [FLAG_W-1:0] BUBBLE = {FLAG_W{1'b0}};

   // ID/EX keeps the whole word; later stages keep only the slices still needed.
   typedef struct packed {
      logic              valid;
      logic [FLAG_W-1:0] flags;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } idex_t;

   typedef struct packed {
      logic                  valid;
      logic [MEM_CTRL_W-1:0] mem_ctrl;
      logic [WB_CTRL_W-1:0]  wb_ctrl;
      logic [REG_W-1:0]      dest;
   } exmem_t;

   typedef struct packed {
      logic                 valid;
      logic [WB_CTRL_W-1:0] wb_ctrl;
      logic [REG_W-1:0]     dest;
   } memwb_t;

   function automatic logic [EX_CTRL_W-1:0] ex_slice(input logic [FLAG_W-1:0] f);
      return {f[F_REGDST], f[F_ALUSRC], f[F_ALUOP +: ALUOP_W]};
   endfunction

   function automatic logic [MEM_CTRL_W-1:0] mem_slice(input logic [FLAG_W-1:0] f);
      return {f[F_MEMREAD], f[F_MEMWRITE], f[F_BRANCH], f[F_JUMP]};
   endfunction

   function automatic logic [WB_CTRL_W-1:0] wb_slice(input logic [FLAG_W-1:0] f);
      return {f[F_REGWRITE], f[F_MEMTOREG]};
   endfunction

endpackage

// File: rtl/ctrl_flag_pipe_stage_reg.sv
// Generic pipeline stage register: hold freezes the contents and beats clear,
// clear loads an all-zero bubble.
module ctrl_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Stage storage with hold > clear > load priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= {W{1'b0}};
      end else if (hold) begin
         q <= q;
      end else if (clear) begin
         q <= {W{1'b0}};
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/ctrl_flag_pipe.sv
// Carries the decoded control word through ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards and inserts bubbles on stall and flush.
module ctrl_flag_pipe
   import ctrl_flag_pipe_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FLAG_W-1:0]     flags_id,
   input  logic                  valid_id,
   input  logic [REG_W-1:0]      rs_id,
   input  logic [REG_W-1:0]      rt_id,
   input  logic [REG_W-1:0]      rd_id,
   input  logic                  hold_i,
   input  logic                  flush_i,
   output logic                  stall_o,
   output logic [EX_CTRL_W-1:0]  ex_ctrl,
   output logic [REG_W-1:0]      ex_rt,
   output logic [MEM_CTRL_W-1:0] mem_ctrl,
   output logic [REG_W-1:0]      mem_dest,
   output logic [WB_CTRL_W-1:0]  wb_ctrl,
   output logic [REG_W-1:0]      wb_dest,
   output logic [CNT_W-1:0]      bubble_cnt
);

   idex_t            idex_d, idex_q;
   exmem_t           exmem_d, exmem_q;
   memwb_t           memwb_d, memwb_q;
   logic             haz_s;
   logic             idex_clear_s;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   ctrl_stage_reg #(.W($bits(idex_t))) u_idex (
      .clk   (clk),
      .reset (reset),
      .hold  (hold_i),
      .clear (idex_clear_s),
      .d     (idex_d),
      .q     (idex_q)
   );

   ctrl_stage_reg #(.W($bits(exmem_t))) u_exmem (
      .clk   (clk),
      .reset (reset),
      .hold  (hold_i),
      .clear (flush_i),
      .d     (exmem_d),
      .q     (exmem_q)
   );

   // MEM/WB is never cleared: on a flush the branch in EX/MEM still retires.
   ctrl_stage_reg #(.W($bits(memwb_t))) u_memwb (
      .clk   (clk),
      .reset (reset),
      .hold  (hold_i),
      .clear (1'b0),
      .d     (memwb_d),
      .q     (memwb_q)
   );

   // Load-use detection against the load sitting in ID/EX; $0 never conflicts.
   always_comb begin
      haz_s = idex_q.valid
            & idex_q.flags[F_MEMREAD]
            & idex_q.flags[F_REGWRITE]
            & (idex_q.rt != {REG_W{1'b0}})
            & valid_id
            & ((idex_q.rt == rs_id) | (idex_q.rt == rt_id));
      idex_clear_s = flush_i | haz_s;
      stall_o      = hold_i | (haz_s & ~flush_i);
   end

   // Next-state words for the three stages, including the EX destination mux.
   always_comb begin
      idex_d = '0;
      if (valid_id) begin
         idex_d.valid = 1'b1;
         idex_d.flags = flags_id;
         idex_d.rt    = rt_id;
         idex_d.rd    = rd_id;
      end else begin
         idex_d.flags = BUBBLE;
      end

      exmem_d          = '0;
      exmem_d.valid    = idex_q.valid;
      exmem_d.mem_ctrl = mem_slice(idex_q.flags);
      exmem_d.wb_ctrl  = wb_slice(idex_q.flags);
      if (idex_q.flags[F_REGDST]) begin
         exmem_d.dest = idex_q.rd;
      end else begin
         exmem_d.dest = idex_q.rt;
      end

      memwb_d         = '0;
      memwb_d.valid   = exmem_q.valid;
      memwb_d.wb_ctrl = exmem_q.wb_ctrl;
      memwb_d.dest    = exmem_q.dest;
   end

   // Bubble counter: counts only hazard bubbles that actually land, saturating.
   always_comb begin
      cnt_d = cnt_q;
      if (hold_i) begin
         cnt_d = cnt_q;
      end else if (flush_i) begin
         cnt_d = cnt_q;
      end else if (haz_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Per-stage outputs, forced to zero when the stage holds no instruction.
   always_comb begin
      ex_ctrl  = {EX_CTRL_W{1'b0}};
      ex_rt    = {REG_W{1'b0}};
      mem_ctrl = {MEM_CTRL_W{1'b0}};
      mem_dest = {REG_W{1'b0}};
      wb_ctrl  = {WB_CTRL_W{1'b0}};
      wb_dest  = {REG_W{1'b0}};
      if (idex_q.valid) begin
         ex_ctrl = ex_slice(idex_q.flags);
         ex_rt   = idex_q.rt;
      end else begin
         ex_ctrl = {EX_CTRL_W{1'b0}};
      end
      if (exmem_q.valid) begin
         mem_ctrl = exmem_q.mem_ctrl;
         mem_dest = exmem_q.dest;
      end else begin
         mem_ctrl = {MEM_CTRL_W{1'b0}};
      end
      if (memwb_q.valid) begin
         wb_ctrl = memwb_q.wb_ctrl;
         wb_dest = memwb_q.dest;
      end else begin
         wb_ctrl = {WB_CTRL_W{1'b0}};
      end
      bubble_cnt = cnt_q;
   end

endmodule

// File: tb/tb_ctrl_flag_pipe.sv
// Directed bench for ctrl_flag_pipe: each step queues its hand-derived expected
// outputs, which are popped and compared once the clock edge has happened.
module tb_ctrl_flag_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  flags_id;
   logic        valid_id;
   logic [4:0]  rs_id, rt_id, rd_id;
   logic        hold_i, flush_i;
   logic        stall_o;
   logic [3:0]  ex_ctrl;
   logic [4:0]  ex_rt;
   logic [3:0]  mem_ctrl;
   logic [4:0]  mem_dest;
   logic [1:0]  wb_ctrl;
   logic [4:0]  wb_dest;
   logic [15:0] bubble_cnt;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   typedef struct packed {
      logic [3:0]  ex;
      logic [4:0]  exrt;
      logic [3:0]  mem;
      logic [4:0]  md;
      logic [1:0]  wb;
      logic [4:0]  wd;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   ctrl_flag_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .flags_id   (flags_id),
      .valid_id   (valid_id),
      .rs_id      (rs_id),
      .rt_id      (rt_id),
      .rd_id      (rd_id),
      .hold_i     (hold_i),
      .flush_i    (flush_i),
      .stall_o    (stall_o),
      .ex_ctrl    (ex_ctrl),
      .ex_rt      (ex_rt),
      .mem_ctrl   (mem_ctrl),
      .mem_dest   (mem_dest),
      .wb_ctrl    (wb_ctrl),
      .wb_dest    (wb_dest),
      .bubble_cnt (bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] ex, input logic [4:0] exrt,
                               input logic [3:0] mem, input logic [4:0] md,
                               input logic [1:0] wb, input logic [4:0] wd,
                               input logic [15:0] cnt);
      exp_t e;
      e.ex = ex; e.exrt = exrt; e.mem = mem; e.md = md;
      e.wb = wb; e.wd = wd; e.cnt = cnt;
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
      chk({tag, "_ex"},    {28'd0, ex_ctrl}, 32'd0);
      chk({tag, "_exrt"},  {27'd0, ex_rt}, 32'd0);
      chk({tag, "_mem"},   {28'd0, mem_ctrl}, 32'd0);
      chk({tag, "_md"},    {27'd0, mem_dest}, 32'd0);
      chk({tag, "_wb"},    {30'd0, wb_ctrl}, 32'd0);
      chk({tag, "_wd"},    {27'd0, wb_dest}, 32'd0);
      chk({tag, "_cnt"},   {16'd0, bubble_cnt}, 32'd0);
   endtask

   // Called at posedge+1: drive, check stall before the edge, check state after.
   task automatic step(input logic [9:0] f, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic hd,
                       input logic fl, input logic e_stall, input exp_t e);
      exp_t got;
      step_no++;
      flags_id = f; valid_id = v; rs_id = rs; rt_id = rt; rd_id = rd;
      hold_i = hd; flush_i = fl;
      exp_q.push_back(e);
      @(negedge clk);
      chk("stall", {31'd0, stall_o}, {31'd0, e_stall});
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("ex_ctrl",    {28'd0, ex_ctrl},    {28'd0, got.ex});
      chk("ex_rt",      {27'd0, ex_rt},      {27'd0, got.exrt});
      chk("mem_ctrl",   {28'd0, mem_ctrl},   {28'd0, got.mem});
      chk("mem_dest",   {27'd0, mem_dest},   {27'd0, got.md});
      chk("wb_ctrl",    {30'd0, wb_ctrl},    {30'd0, got.wb});
      chk("wb_dest",    {27'd0, wb_dest},    {27'd0, got.wd});
      chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, got.cnt});
   endtask

   task automatic nop(input exp_t e);
      step(10'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e);
   endtask

   initial begin
      reset = 1'b1;
      flags_id = 10'h000; valid_id = 1'b0;
      rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
      hold_i = 1'b0; flush_i = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Straight flow: R-type 10'h241, rd=7.
      step(10'h241, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd2, 4'h0, 5'd0, 2'b00, 5'd0, 16'd0));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd7, 2'b00, 5'd0, 16'd0));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b10, 5'd7, 16'd0));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd0));

      // Load-use: lw rt=3 then add rs=3 -> one bubble.
      step(10'h1E0, 1'b1, 5'd1, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, mk(4'h4, 5'd3, 4'h0, 5'd0, 2'b00, 5'd0, 16'd0));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1, mk(4'h0, 5'd0, 4'h8, 5'd3, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd4, 4'h0, 5'd0, 2'b11, 5'd3, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd5, 2'b00, 5'd0, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b10, 5'd5, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));

      // Register 0 never stalls.
      step(10'h1E0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, mk(4'h4, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd0, 4'h8, 5'd0, 2'b00, 5'd0, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd6, 2'b11, 5'd0, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b10, 5'd6, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));

      // Flush on the same edge as a hazard: MEM/WB takes the old EX/MEM.
      step(10'h241, 1'b1, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd2, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h1E0, 1'b1, 5'd1, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, mk(4'h4, 5'd3, 4'h0, 5'd7, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b0, mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b10, 5'd7, 16'd1));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));

      // Hold for 3 cycles during load-use (flush during hold ignored), then one bubble.
      step(10'h1E0, 1'b1, 5'd1, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, mk(4'h4, 5'd3, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, mk(4'h4, 5'd3, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, mk(4'h4, 5'd3, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, mk(4'h4, 5'd3, 4'h0, 5'd0, 2'b00, 5'd0, 16'd1));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1, mk(4'h0, 5'd0, 4'h8, 5'd3, 2'b00, 5'd0, 16'd2));
      step(10'h241, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd4, 4'h0, 5'd0, 2'b11, 5'd3, 16'd2));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd5, 2'b00, 5'd0, 16'd2));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b10, 5'd5, 16'd2));
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd2));

      // Three valid words in flight, then reset between edges.
      step(10'h241, 1'b1, 5'd1, 5'd2,  5'd7, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd2,  4'h0, 5'd0, 2'b00, 5'd0, 16'd2));
      step(10'h241, 1'b1, 5'd1, 5'd10, 5'd8, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd10, 4'h0, 5'd7, 2'b00, 5'd0, 16'd2));
      step(10'h241, 1'b1, 5'd1, 5'd11, 5'd9, 1'b0, 1'b0, 1'b0, mk(4'h9, 5'd11, 4'h0, 5'd8, 2'b10, 5'd7, 16'd2));
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      flags_id = 10'h000; valid_id = 1'b0;
      rs_id = 5'd0; rt_id = 5'd0; rd_id = 5'd0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      nop(mk(4'h0, 5'd0, 4'h0, 5'd0, 2'b00, 5'd0, 16'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
